// File: rtl/bcd_down_timer.sv
// Two-digit loadable BCD down-counter (Q = ones, W = tens) with prescaler,
// terminal-count pulse, one-shot or auto-reload behaviour and load error flag.
module bcd_down_timer #(
    parameter int         TICK_DIV       = 1,
    parameter logic [7:0] RELOAD_DEFAULT = 8'h00
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       auto_reload,
    output logic [3:0] Q,
    output logic [3:0] W,
    output logic       zero,
    output logic       tc,
    output logic       busy,
    output logic       load_err
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic [7:0]    reload_q, reload_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tc_q, tc_d;
    logic          err_q, err_d;
    logic          loadValid;
    logic          tick;

    assign loadValid = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
    assign tick      = (state_q == RUN) && en && (presc_q == PRESC_MAX);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ones_q   <= 4'd0;
            tens_q   <= 4'd0;
            reload_q <= RELOAD_DEFAULT;
            presc_q  <= '0;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ones_q   <= ones_d;
            tens_q   <= tens_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            tc_q     <= tc_d;
            err_q    <= err_d;
        end
    end

    // A load always wins over a coincident tick, even when the load is rejected.
    always_comb begin
        state_d  = state_q;
        ones_d   = ones_q;
        tens_d   = tens_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        tc_d     = 1'b0;
        err_d    = err_q;

        if (load) begin
            if (loadValid) begin
                tens_d   = load_val[7:4];
                ones_d   = load_val[3:0];
                reload_d = load_val;
                presc_d  = '0;
                err_d    = 1'b0;
                state_d  = (load_val != 8'h00) ? RUN : IDLE;
            end else begin
                err_d = 1'b1;
            end
        end else if (state_q == RUN && en) begin
            if (tick) begin
                presc_d = '0;
                if (ones_q != 4'd0) begin
                    ones_d = ones_q - 4'd1;
                    if (ones_q == 4'd1 && tens_q == 4'd0) begin
                        tc_d = 1'b1;
                        if (!auto_reload) begin
                            state_d = DONE;
                        end
                    end
                end else if (tens_q != 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else if (auto_reload) begin
                    // 00 is held for one full tick before reloading
                    tens_d = reload_q[7:4];
                    ones_d = reload_q[3:0];
                end else begin
                    state_d = DONE;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    assign Q        = ones_q;
    assign W        = tens_q;
    assign zero     = (ones_q == 4'd0) && (tens_q == 4'd0);
    assign tc       = tc_q;
    assign busy     = (state_q == RUN);
    assign load_err = err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: two instances (TICK_DIV 1 and 3) on shared inputs,
// checked against hand tables and an integer-arithmetic reference model.
module tb_bcd_down_timer;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    typedef struct packed {
        int   cnt;
        int   rld;
        int   ph;
        int   st;
        logic tc;
        logic err;
    } mdl_t;

    typedef struct packed {
        logic       en;
        logic       ld;
        logic [7:0] lv;
        logic       ar;
        logic [7:0] cnt;
        logic       tc;
        logic       busy;
        logic       err;
    } vec_t;

    logic       ck = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic       ar;
    logic [7:0] lv;
    logic [3:0] q1, w1, q3, w3;
    logic       z1, tc1, b1, e1, z3, tc3, b3, e3;
    logic [11:0] act1, act3;

    int   vectors = 0;
    int   miscompares = 0;
    mdl_t m1, m3;
    vec_t tbl[$];

    always #5 ck = ~ck;

    bcd_down_timer #(.TICK_DIV(1), .RELOAD_DEFAULT(8'h00)) dut1 (
        .ck(ck), .rst(rst), .en(en), .load(load), .load_val(lv), .auto_reload(ar),
        .Q(q1), .W(w1), .zero(z1), .tc(tc1), .busy(b1), .load_err(e1)
    );

    bcd_down_timer #(.TICK_DIV(3), .RELOAD_DEFAULT(8'h00)) dut3 (
        .ck(ck), .rst(rst), .en(en), .load(load), .load_val(lv), .auto_reload(ar),
        .Q(q3), .W(w3), .zero(z3), .tc(tc3), .busy(b3), .load_err(e3)
    );

    assign act1 = {w1, q1, z1, tc1, b1, e1};
    assign act3 = {w3, q3, z3, tc3, b3, e3};

    function automatic mdl_t modelReset();
        mdl_t m;
        m.cnt = 0; m.rld = 0; m.ph = 0; m.st = S_IDLE; m.tc = 1'b0; m.err = 1'b0;
        return m;
    endfunction

    // Count is a plain integer 0..99; digits are derived only when comparing.
    function automatic mdl_t modelStep(mdl_t m, int div, logic e, logic l,
                                       logic [7:0] v, logic a);
        mdl_t n;
        int   hi, lo;
        n  = m;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        n.tc = 1'b0;
        if (l) begin
            if (hi <= 9 && lo <= 9) begin
                n.cnt = hi * 10 + lo;
                n.rld = n.cnt;
                n.ph  = 0;
                n.err = 1'b0;
                n.st  = (n.cnt != 0) ? S_RUN : S_IDLE;
            end else begin
                n.err = 1'b1;
            end
        end else if (m.st == S_RUN && e) begin
            if (m.ph == div - 1) begin
                n.ph = 0;
                if (m.cnt > 0) begin
                    n.cnt = m.cnt - 1;
                    if (n.cnt == 0) begin
                        n.tc = 1'b1;
                        if (!a) n.st = S_DONE;
                    end
                end else if (a) begin
                    n.cnt = m.rld;
                end else begin
                    n.st = S_DONE;
                end
            end else begin
                n.ph = m.ph + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [11:0] expVec(mdl_t m);
        logic [3:0] w, q;
        w = 4'(m.cnt / 10);
        q = 4'(m.cnt % 10);
        return {w, q, (m.cnt == 0), m.tc, (m.st == S_RUN), m.err};
    endfunction

    function automatic logic [11:0] tblVec(logic [7:0] c, logic t, logic b, logic er);
        return {c, (c == 8'h00), t, b, er};
    endfunction

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got W=%h Q=%h zero=%b tc=%b busy=%b err=%b, want W=%h Q=%h zero=%b tc=%b busy=%b err=%b",
                     name, act[11:8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic cycle();
        @(posedge ck);
        m1 = modelStep(m1, 1, en, load, lv, ar);
        m3 = modelStep(m3, 3, en, load, lv, ar);
        #1;
        checkOutput("model dut1", act1, expVec(m1));
        checkOutput("model dut3", act3, expVec(m3));
    endtask

    task automatic applyStimulus(input logic e, input logic l, input logic [7:0] v, input logic a);
        en = e; load = l; lv = v; ar = a;
        cycle();
    endtask

    task automatic addVec(input logic e, input logic l, input logic [7:0] v, input logic a,
                          input logic [7:0] c, input logic t, input logic b, input logic er);
        vec_t x;
        x.en = e; x.ld = l; x.lv = v; x.ar = a; x.cnt = c; x.tc = t; x.busy = b; x.err = er;
        tbl.push_back(x);
    endtask

    task automatic runTable(input bit useDut3, input string tag);
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].en, tbl[i].ld, tbl[i].lv, tbl[i].ar);
            checkOutput($sformatf("%s[%0d]", tag, i), useDut3 ? act3 : act1,
                        tblVec(tbl[i].cnt, tbl[i].tc, tbl[i].busy, tbl[i].err));
        end
        tbl.delete();
    endtask

    initial begin
        logic [7:0] c;
        logic [7:0] r;

        rst = 1'b1; en = 1'b0; load = 1'b0; lv = 8'h00; ar = 1'b0;
        m1 = modelReset();
        m3 = modelReset();
        #12;
        checkOutput("reset dut1", act1, 12'h008);
        checkOutput("reset dut3", act3, 12'h008);
        @(negedge ck);
        rst = 1'b0;

        // Load errors, auto-reload period, digit borrow, en freeze, one-shot DONE
        addVec(0, 1, 8'h1A, 0, 8'h00, 0, 0, 1);
        addVec(1, 1, 8'h25, 0, 8'h25, 0, 1, 0);
        addVec(1, 1, 8'h1A, 0, 8'h25, 0, 1, 1);
        addVec(1, 0, 8'h00, 0, 8'h24, 0, 1, 1);
        addVec(1, 1, 8'h00, 0, 8'h00, 0, 0, 0);
        addVec(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        addVec(1, 1, 8'h03, 1, 8'h03, 0, 1, 0);
        addVec(1, 0, 8'h00, 1, 8'h02, 0, 1, 0);
        addVec(1, 0, 8'h00, 1, 8'h01, 0, 1, 0);
        addVec(1, 0, 8'h00, 1, 8'h00, 1, 1, 0);
        addVec(1, 0, 8'h00, 1, 8'h03, 0, 1, 0);
        addVec(1, 0, 8'h00, 1, 8'h02, 0, 1, 0);
        addVec(1, 0, 8'h00, 1, 8'h01, 0, 1, 0);
        addVec(1, 0, 8'h00, 1, 8'h00, 1, 1, 0);
        addVec(1, 0, 8'h00, 1, 8'h03, 0, 1, 0);
        addVec(1, 1, 8'h40, 0, 8'h40, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h39, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h38, 0, 1, 0);
        addVec(0, 0, 8'h00, 0, 8'h38, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h37, 0, 1, 0);
        addVec(1, 1, 8'h02, 0, 8'h02, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h01, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h00, 1, 0, 0);
        addVec(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        addVec(1, 1, 8'h01, 1, 8'h01, 0, 1, 0);
        addVec(1, 0, 8'h00, 1, 8'h00, 1, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        addVec(1, 0, 8'h00, 1, 8'h00, 0, 0, 0);
        runTable(1'b0, "table1");

        // One-shot countdown from 12 to 00, then holding in DONE
        applyStimulus(1, 1, 8'h12, 0);
        checkOutput("t2 load", act1, tblVec(8'h12, 0, 1, 0));
        for (int i = 11; i >= 0; i--) begin
            applyStimulus(1, 0, 8'h00, 0);
            c = {4'(i / 10), 4'(i % 10)};
            checkOutput($sformatf("t2 count %0d", i), act1, tblVec(c, (i == 0), (i != 0), 0));
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 8'h00, 0);
            checkOutput("t2 hold", act1, tblVec(8'h00, 0, 0, 0));
        end

        // Asynchronous reset while tc and load_err are both high
        applyStimulus(1, 1, 8'h01, 0);
        applyStimulus(1, 1, 8'h1A, 0);
        applyStimulus(1, 0, 8'h00, 0);
        checkOutput("t1 pre-reset", act1, tblVec(8'h00, 1, 0, 1));
        #2 rst = 1'b1;
        #1;
        checkOutput("t1 async dut1", act1, 12'h008);
        checkOutput("t1 async dut3", act3, 12'h008);
        #2 rst = 1'b0;
        m1 = modelReset();
        m3 = modelReset();

        // Prescaler of 3: freeze under en low, load on a tick cycle restarts it
        addVec(1, 1, 8'h05, 0, 8'h05, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h05, 0, 1, 0);
        addVec(0, 0, 8'h00, 0, 8'h05, 0, 1, 0);
        addVec(0, 0, 8'h00, 0, 8'h05, 0, 1, 0);
        addVec(0, 0, 8'h00, 0, 8'h05, 0, 1, 0);
        addVec(0, 0, 8'h00, 0, 8'h05, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h05, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h04, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h04, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h04, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h03, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h03, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h03, 0, 1, 0);
        addVec(1, 1, 8'h07, 0, 8'h07, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h07, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h07, 0, 1, 0);
        addVec(1, 0, 8'h00, 0, 8'h06, 0, 1, 0);
        runTable(1'b1, "table3");

        // Random traffic against the reference model
        ar = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 4) == 0) r = 8'($urandom);
            else r = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0), r,
                          ($urandom_range(0, 19) == 0) ? ~ar : ar);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
